// File: rtl/hdmi_capture_ctrl.sv
// Frame-capture controller: gates FIFO writes for a requested number of frames.
// Optional line/frame geometry checking is enabled with HDMI_CAPTURE_LINE_CHECK_EN.
module hdmi_capture_ctrl #(
  parameter int H_TOTAL = 1920,
  parameter int V_TOTAL = 1080
) (
  input  logic       hdmi_in_clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       abort,
  input  logic [7:0] num_frames,
  input  logic       hdmi_in_vs,
  input  logic       hdmi_in_active,
  input  logic       fifo_full,
  output logic       cap_en,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] frames_captured,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    CAPTURE = 3'd2,
    DONE    = 3'd3,
    OVFL    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] target_q, target_d;
  logic [7:0] frames_q, frames_d;
  logic       overflow_q, overflow_d;
  logic       vs_prev_q, vs_edge_q;
  logic       ovf_cond;
  logic [7:0] frames_inc;

  assign ovf_cond   = (state_q == CAPTURE) & hdmi_in_active & fifo_full;
  assign frames_inc = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;

  always_ff @(posedge hdmi_in_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= 8'd0;
      frames_q   <= 8'd0;
      overflow_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      vs_edge_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      frames_q   <= frames_d;
      overflow_q <= overflow_d;
      vs_prev_q  <= hdmi_in_vs;
      vs_edge_q  <= hdmi_in_vs & ~vs_prev_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    frames_d   = frames_q;
    overflow_d = overflow_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm && (num_frames != 8'd0)) begin
            target_d   = num_frames;
            frames_d   = 8'd0;
            overflow_d = 1'b0;
            state_d    = WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (vs_edge_q) begin
            frames_d = 8'd0;
            state_d  = CAPTURE;
          end
        end
        CAPTURE: begin
          // A FIFO overrun outranks a coincident frame boundary.
          if (ovf_cond) begin
            overflow_d = 1'b1;
            state_d    = OVFL;
          end else if (vs_edge_q) begin
            frames_d = frames_inc;
            if (frames_inc == target_q) state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        OVFL: begin
          if (arm) begin
            overflow_d = 1'b0;
            if (num_frames != 8'd0) target_d = num_frames;
            state_d = WAIT_VS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cap_en          = (state_q == CAPTURE) & hdmi_in_active & ~fifo_full;
  assign busy            = (state_q == WAIT_VS) | (state_q == CAPTURE);
  assign done            = (state_q == DONE);
  assign overflow        = overflow_q;
  assign frames_captured = frames_q;
  assign state           = state_q;

`ifdef HDMI_CAPTURE_LINE_CHECK_EN
  localparam logic [11:0] H_CMP = 12'(H_TOTAL);
  localparam logic [11:0] V_CMP = 12'(V_TOTAL);

  logic [11:0] pix_cnt_q, line_cnt_q;
  logic        frame_err_q, active_prev_q;
  logic        active_fall, clear_err;

  assign active_fall = active_prev_q & ~hdmi_in_active;
  assign clear_err   = (state_q == IDLE) & arm & ~abort & (num_frames != 8'd0);

  always_ff @(posedge hdmi_in_clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q     <= 12'd0;
      line_cnt_q    <= 12'd0;
      frame_err_q   <= 1'b0;
      active_prev_q <= 1'b0;
    end else begin
      active_prev_q <= hdmi_in_active;
      if (clear_err) frame_err_q <= 1'b0;
      // Geometry counters only live inside a capture; elsewhere they are held at zero.
      if (state_q != CAPTURE) begin
        pix_cnt_q  <= 12'd0;
        line_cnt_q <= 12'd0;
      end else begin
        if (active_fall) begin
          if (pix_cnt_q != H_CMP) frame_err_q <= 1'b1;
          line_cnt_q <= line_cnt_q + 12'd1;
          pix_cnt_q  <= 12'd0;
        end else if (hdmi_in_active) begin
          pix_cnt_q <= pix_cnt_q + 12'd1;
        end
        if (vs_edge_q) begin
          if (line_cnt_q != V_CMP) frame_err_q <= 1'b1;
          line_cnt_q <= 12'd0;
        end
      end
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// Directed bench for hdmi_capture_ctrl using a reduced 16x4 frame geometry.
module tb_hdmi_capture_ctrl;

  localparam int H = 16;
  localparam int V = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm, abort;
  logic [7:0] num_frames;
  logic       vs, active, ff;
  logic       cap_en, busy, done, overflow, frame_err;
  logic [7:0] frames_captured;
  logic [2:0] state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cap_cnt = 0;
  int done_cnt = 0;

`ifdef HDMI_CAPTURE_LINE_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  hdmi_capture_ctrl #(.H_TOTAL(H), .V_TOTAL(V)) dut (
    .hdmi_in_clk     (clk),
    .rst             (rst),
    .arm             (arm),
    .abort           (abort),
    .num_frames      (num_frames),
    .hdmi_in_vs      (vs),
    .hdmi_in_active  (active),
    .fifo_full       (ff),
    .cap_en          (cap_en),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .frame_err       (frame_err),
    .frames_captured (frames_captured),
    .state           (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    else pass_cnt++;
  endtask

  // One clock: cap_en/done sampled mid-cycle, registered outputs settle #1 after the edge.
  task automatic step();
    @(negedge clk);
    cap_cnt  += int'(cap_en);
    done_cnt += int'(done);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic ab, input logic [7:0] nf,
                       input logic v, input logic act, input logic f);
    arm = a; abort = ab; num_frames = nf; vs = v; active = act; ff = f;
    step();
  endtask

  // vs pulse, two blank cycles, then nlines lines of active video with 3 blank cycles each.
  task automatic send_frame(input int nlines, input int short_line, input int ovf_line,
                            input int ovf_pix, input int abort_at);
    int idx = 0;
    drive(0, 0, 8'd0, 1, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0);
    drive(0, 0, 8'd0, 0, 0, 0);
    drive(0, 0, 8'd0, 0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      int npix = (l == short_line) ? H - 1 : H;
      for (int p = 0; p < npix; p++) begin
        drive(0, logic'(idx == abort_at), 8'd0, 0, 1, logic'((l == ovf_line) && (p >= ovf_pix)));
        idx++;
      end
      for (int b = 0; b < 3; b++) drive(0, 0, 8'd0, 0, 0, 0);
    end
  endtask

  task automatic clr_counts();
    cap_cnt = 0;
    done_cnt = 0;
  endtask

  typedef struct {
    logic       arm;
    logic       abort;
    logic [7:0] nf;
    logic       vs;
    logic       act;
    logic       ff;
    logic       e_cap;
    logic [2:0] e_state;
    logic       e_busy;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[13];

  initial begin
    rst = 1'b1; arm = 0; abort = 0; num_frames = 0; vs = 0; active = 0; ff = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cap_en", cap_en, 0);
    chk("rst_frames", frames_captured, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //            arm ab nf    vs act ff cap st busy ovf
    vecs[0]  = '{1, 1, 8'd2, 0, 0, 0, 0, 3'd0, 0, 0}; // arm+abort in IDLE
    vecs[1]  = '{1, 0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0}; // arm with zero frames
    vecs[2]  = '{0, 0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0};
    vecs[3]  = '{1, 0, 8'd1, 0, 0, 0, 0, 3'd1, 1, 0};
    vecs[4]  = '{0, 0, 8'd0, 1, 0, 0, 0, 3'd1, 1, 0}; // vs rises, flag not yet seen
    vecs[5]  = '{0, 0, 8'd0, 1, 0, 0, 0, 3'd2, 1, 0};
    vecs[6]  = '{0, 0, 8'd0, 0, 1, 0, 1, 3'd2, 1, 0};
    vecs[7]  = '{0, 0, 8'd0, 0, 1, 1, 0, 3'd4, 0, 1}; // overrun
    vecs[8]  = '{1, 0, 8'd3, 0, 0, 0, 0, 3'd1, 1, 0}; // re-arm from OVFL
    vecs[9]  = '{0, 1, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0};
    vecs[10] = '{1, 0, 8'd5, 0, 0, 0, 0, 3'd1, 1, 0};
    vecs[11] = '{1, 0, 8'd1, 0, 0, 0, 0, 3'd1, 1, 0}; // arm ignored in WAIT_VS
    vecs[12] = '{0, 1, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      arm = vecs[i].arm; abort = vecs[i].abort; num_frames = vecs[i].nf;
      vs = vecs[i].vs; active = vecs[i].act; ff = vecs[i].ff;
      @(negedge clk);
      chk($sformatf("vec%0d_cap_en", i), cap_en, vecs[i].e_cap);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
      chk($sformatf("vec%0d_done", i), done, 0);
      $display("vec %0d: state=%0d busy=%0d cap_en=%0d overflow=%0d", i, state, busy, cap_en, overflow);
    end
    drive(0, 0, 8'd0, 0, 0, 0);

    // Two-frame capture; third vs ends it, trailing line must not be written.
    clr_counts();
    drive(1, 0, 8'd2, 0, 0, 0);
    send_frame(V, -1, -1, 0, -1);
    send_frame(V, -1, -1, 0, -1);
    send_frame(1, -1, -1, 0, -1);
    chk("two_frame_cap_cycles", cap_cnt, 2 * V * H);
    chk("two_frame_done_pulses", done_cnt, 1);
    chk("two_frame_frames", frames_captured, 2);
    chk("two_frame_state", state, 0);
    chk("two_frame_frame_err", frame_err, 0);
    $display("two-frame capture: cap_cycles=%0d done_pulses=%0d frames=%0d", cap_cnt, done_cnt, frames_captured);

    // FIFO full on line 2 pixel 10 of the first frame.
    clr_counts();
    drive(1, 0, 8'd3, 0, 0, 0);
    send_frame(V, -1, 2, 10, -1);
    chk("ovf_cap_cycles", cap_cnt, 2 * H + 10);
    chk("ovf_state", state, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_busy", busy, 0);
    drive(1, 0, 8'd3, 0, 0, 0);
    chk("ovf_rearm_state", state, 1);
    chk("ovf_rearm_flag", overflow, 0);
    drive(0, 1, 8'd0, 0, 0, 0);
    chk("ovf_abort_state", state, 0);
    $display("overflow: cap_cycles=%0d state=%0d", cap_cnt, state);

    // Abort on the 40th active cycle of the first frame.
    clr_counts();
    drive(1, 0, 8'd2, 0, 0, 0);
    send_frame(V, -1, -1, 0, 39);
    chk("abort_cap_cycles", cap_cnt, 40);
    chk("abort_state", state, 0);
    chk("abort_frames", frames_captured, 0);
    chk("abort_done_pulses", done_cnt, 0);
    $display("abort: cap_cycles=%0d state=%0d", cap_cnt, state);

    // Short line in frame 1, capture still completes.
    clr_counts();
    drive(1, 0, 8'd2, 0, 0, 0);
    send_frame(V, 1, -1, 0, -1);
    send_frame(V, -1, -1, 0, -1);
    send_frame(0, -1, -1, 0, -1);
    chk("short_line_frame_err", frame_err, ERR_EXP);
    chk("short_line_done_pulses", done_cnt, 1);
    chk("short_line_frames", frames_captured, 2);
    chk("short_line_cap_cycles", cap_cnt, 2 * V * H - 1);
    $display("short line: frame_err=%0d frames=%0d", frame_err, frames_captured);

    // Frame one line short; arm must clear the sticky error first.
    clr_counts();
    drive(1, 0, 8'd1, 0, 0, 0);
    chk("arm_clears_frame_err", frame_err, 0);
    send_frame(V - 1, -1, -1, 0, -1);
    send_frame(0, -1, -1, 0, -1);
    chk("short_frame_frame_err", frame_err, ERR_EXP);
    chk("short_frame_done_pulses", done_cnt, 1);
    chk("short_frame_frames", frames_captured, 1);
    $display("short frame: frame_err=%0d frames=%0d", frame_err, frames_captured);

    // Asynchronous reset in the middle of an active line.
    drive(1, 0, 8'd2, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0);
    drive(0, 0, 8'd0, 0, 0, 0);
    drive(0, 0, 8'd0, 0, 1, 0);
    drive(0, 0, 8'd0, 0, 1, 0);
    chk("pre_rst_cap_en", cap_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cap_en", cap_en, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frames", frames_captured, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_frame_err", frame_err, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    active = 0;
    step();
    chk("post_rst_state", state, 0);
    $display("async reset: state=%0d cap_en=%0d", state, cap_en);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hdmi_capture_ctrl.md
HDMI_CAPTURE_CTRL -- requirements
Module: hdmi_capture_ctrl

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1920, expected active pixels per line.
REQ-002 SHALL have parameter V_TOTAL, default 1080, expected active lines per frame.
REQ-003 SHALL have port hdmi_in_clk  input  1  capture clock; all logic is synchronous to it.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port arm  input  1  one-cycle capture request.
REQ-006 SHALL have port abort  input  1  one-cycle cancel request.
REQ-007 SHALL have port num_frames  input  8  frames to capture; sampled on an accepted arm.
REQ-008 SHALL have ports hdmi_in_vs, hdmi_in_active  input  1 each  video timing from the capture pipe.
REQ-009 SHALL have port fifo_full  input  1  capture FIFO full flag (write domain).
REQ-010 SHALL have port cap_en  output  1  FIFO write gate.
REQ-011 SHALL have ports busy, done, overflow, frame_err  output  1 each  status.
REQ-012 SHALL have port frames_captured  output  8  completed-frame count.
REQ-013 SHALL have port state  output  3  FSM state encoding.

Function
REQ-014 SHALL implement FSM states IDLE=0, WAIT_VS=1, CAPTURE=2, DONE=3, OVFL=4.
REQ-015 SHALL detect a vs edge as hdmi_in_vs=1 with a registered previous vs=0; this flag is registered and available one cycle after vs rises.
REQ-016 IDLE: arm with num_frames!=0 SHALL latch num_frames, clear frames_captured/overflow/frame_err and go to WAIT_VS; arm with num_frames=0 SHALL be ignored.
REQ-017 WAIT_VS: a vs edge SHALL go to CAPTURE with frames_captured=0.
REQ-018 CAPTURE: each vs edge SHALL increment frames_captured; when the incremented value equals the latched target, the FSM SHALL go to DONE.
REQ-019 cap_en SHALL be combinational: (state==CAPTURE) & hdmi_in_active & ~fifo_full.
REQ-020 CAPTURE with hdmi_in_active=1 and fifo_full=1 SHALL set overflow (sticky) and go to OVFL; cap_en SHALL be 0 from that cycle.
REQ-021 OVFL: cap_en=0; the FSM SHALL hold until abort (to IDLE) or arm (to WAIT_VS, clearing overflow).
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 busy SHALL equal (state==WAIT_VS or CAPTURE).
REQ-024 abort SHALL force IDLE on the next edge from any state; frames_captured, overflow and frame_err SHALL be retained.
REQ-025 abort and arm in the same cycle: abort wins.
REQ-026 arm in WAIT_VS, CAPTURE or DONE SHALL be ignored.
REQ-027 vs edge and overflow condition in the same cycle in CAPTURE: overflow wins and frames_captured is not incremented.
REQ-028 frames_captured SHALL saturate at 255.

Reset
REQ-029 rst SHALL force state=IDLE, and set cap_en, busy, done, overflow and frame_err to 0, frames_captured=0, the latched target=0, the internal counters=0 and the previous vs/active registers=0.
REQ-030 rst asserted mid-capture SHALL drop cap_en in the same cycle, because state is asynchronously reset.

Configuration
REQ-031 With macro HDMI_CAPTURE_LINE_CHECK_EN defined:
- a 12-bit pixel counter SHALL count hdmi_in_active cycles in CAPTURE.
- on each falling edge of active: if the pixel count != H_TOTAL, frame_err SHALL be set (sticky); the line counter SHALL be incremented and the pixel counter cleared.
- on each vs edge in CAPTURE: if the line count != V_TOTAL, frame_err SHALL be set; the line counter SHALL be cleared.
- both counters SHALL wrap at 4095.
REQ-032 Without HDMI_CAPTURE_LINE_CHECK_EN, frame_err SHALL be tied 0 and neither counter SHALL exist.

Verification
REQ-033 Scenario: num_frames=2, arm, three vs edges with 1080x1920 active, fifo_full=0 -> cap_en follows active for 2 frames only; frames_captured=2; done pulses 1 cycle; state returns to 0.
REQ-034 Scenario: num_frames=3, fifo_full=1 at pixel 100 of line 5 of frame 1 -> overflow=1, state=4, cap_en=0 thereafter; a following arm -> state=1, overflow=0.
REQ-035 Scenario: abort on the 500th active cycle of frame 1 -> state=0 next edge, cap_en=0, frames_captured=0 retained, done=0.
REQ-036 Scenario: arm and abort in the same cycle in IDLE -> state stays 0; arm with num_frames=0 -> state stays 0, busy=0.
REQ-037 Scenario (HDMI_CAPTURE_LINE_CHECK_EN): one line of 1919 pixels in frame 1 -> frame_err=1 and capture continues to done; frame of 1079 lines -> frame_err=1.
REQ-038 Scenario: rst pulse mid-CAPTURE -> all outputs 0 asynchronously; state=0.
